apb_mem_slave: RTL and testbench
================================

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of paddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, legal values 8/16/32/64: width of pwdata and prdata.
REQ-003 SHALL have parameter DEPTH, default 256: number of DATA_WIDTH-bit memory words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, legal range 0..15: pready-low cycles inserted in each ACCESS phase.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port paddr, input, ADDR_WIDTH bits: byte address.
REQ-008 SHALL have port psel, input, 1 bit: slave select.
REQ-009 SHALL have port penable, input, 1 bit: access-phase flag.
REQ-010 SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port pwdata, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port pstrb, input, DATA_WIDTH/8 bits: byte write strobes; present only with APB_MEM_PSTRB_EN.
REQ-013 SHALL have port pready, output, 1 bit: transfer-complete flag.
REQ-014 SHALL have port prdata, output, DATA_WIDTH bits: read data.
REQ-015 SHALL have port pslverr, output, 1 bit: transfer error flag.

Function
REQ-016 SHALL implement the FSM states IDLE and ACCESS.
REQ-017 SHALL compute the word index as paddr >> log2(DATA_WIDTH/8).
REQ-018 SHALL treat a transfer as erroneous when the index is >= DEPTH or the low log2(DATA_WIDTH/8) paddr bits are nonzero.
REQ-019 IDLE: at an edge with psel=1 and penable=0, SHALL capture paddr, pwrite, pwdata (and pstrb), compute the error flag, load wait counter = WAIT_STATES, and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-020 SHALL use only the captured setup values during ACCESS; changes on paddr, pwrite and pwdata during ACCESS SHALL be ignored.
REQ-021 ACCESS, counter > 0: SHALL hold pready=0 and decrement the counter by 1 per cycle.
REQ-022 ACCESS, counter = 0: SHALL drive pready=1 combinationally in that same cycle.
REQ-023 A transfer SHALL complete at the edge where state=ACCESS, pready=1, psel=1 and penable=1.
REQ-024 On completion the FSM SHALL return to IDLE.
REQ-025 The total latency from setup to completion SHALL be 2+WAIT_STATES cycles.
REQ-026 A write completion without error SHALL update the memory at that edge; a subsequent read of the same address SHALL return the new data.
REQ-027 During a read's pready=1 cycle, prdata SHALL equal mem[captured index], or 0 if erroneous; in all other cycles prdata SHALL be 0.
REQ-028 pslverr SHALL equal pready AND the error flag; an erroneous write SHALL NOT modify memory.
REQ-029 If psel=0 or penable=0 at any edge in ACCESS, the FSM SHALL abort to IDLE with no memory update and no completion.
REQ-030 A setup phase in the cycle immediately after a completion SHALL be accepted, giving back-to-back transfers with no idle cycle.
REQ-031 pready SHALL be 0 in IDLE.

Reset
REQ-032 When rst=1 at an edge, state SHALL go to IDLE, the counter SHALL clear, and all DEPTH words SHALL clear to 0; this applies mid-transfer and discards any pending write.
REQ-033 Out of reset, pready SHALL be 0, prdata SHALL be 0 and pslverr SHALL be 0.

Configuration
REQ-034 With macro APB_MEM_PSTRB_EN defined, pstrb SHALL exist and a write SHALL update only bytes whose strobe bit is 1; pstrb=0 SHALL complete normally with no change; reads SHALL ignore pstrb.
REQ-035 Without APB_MEM_PSTRB_EN, pstrb SHALL be absent and every write SHALL update the full word.

Verification
REQ-036 WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 -> each transfer completes 2 cycles after setup, and the read's pready cycle shows prdata=0xDEADBEEF with pslverr=0.
REQ-037 WAIT_STATES=3: read 0x04 -> pready low for 3 ACCESS cycles, high on the 4th, and prdata=0x00000000 after reset.
REQ-038 DEPTH=256, DATA_WIDTH=32: write to 0x400 and read from 0x002 -> pslverr=1 in the pready cycle, prdata=0, and the memory is unchanged.
REQ-039 Start a write of 0x12345678 to 0x20, drop psel in ACCESS -> abort to IDLE; a subsequent read of 0x20 returns 0.
REQ-040 Assert rst during a waited write to 0x08 -> pready=0 on the next cycle, state is IDLE, and a read of 0x08 returns 0.
REQ-041 APB_MEM_PSTRB_EN: write 0xFFFFFFFF, then write 0x00000000 with pstrb=4'b0101 to 0x0C -> a read returns 0xFF00FF00.

Source files
------------

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB memory slave with programmable wait states and slverr on bad addresses.
// Define APB_MEM_PSTRB_EN to add the pstrb port and byte-masked writes.
module apb_mem_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_MEM_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr
);
   localparam int BW  = DATA_WIDTH / 8;
   localparam int LSB = $clog2(BW);
   localparam int IW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t                r_state, w_next;
   logic [3:0]            r_cnt;
   logic [IW-1:0]         r_idx;
   logic                  r_write, r_err;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [BW-1:0]         r_strb;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_setup, w_err, w_ready, w_wr;
   assign w_idx   = paddr >> LSB;
   assign w_err   = ({1'b0, w_idx} >= (ADDR_WIDTH+1)'(DEPTH)) || |(paddr & ADDR_WIDTH'(BW - 1));
   assign w_setup = psel && !penable;
   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   // Leaving ACCESS happens on completion or on any psel/penable drop (abort).
   always_comb begin
      w_ready = r_state == ACCESS && r_cnt == 4'd0;
      w_wr    = w_ready && psel && penable && r_write && !r_err;
      w_next  = r_state == IDLE ? (w_setup ? ACCESS : IDLE)
                                : (psel && penable && !w_ready ? ACCESS : IDLE);
      pready  = w_ready;
      pslverr = w_ready && r_err;
      prdata  = w_ready && !r_write && !r_err ? r_mem[r_idx] : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_wdata <= '0;
         r_strb  <= '0;
      end else if (r_state == IDLE && w_setup) begin
         r_cnt   <= 4'(WAIT_STATES);
         r_idx   <= w_idx[IW-1:0];
         r_write <= pwrite;
         r_err   <= w_err;
         r_wdata <= pwdata;
`ifdef APB_MEM_PSTRB_EN
         r_strb  <= pstrb;
`else
         r_strb  <= '1;
`endif
      end else if (r_state == ACCESS && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr) begin
         for (int b = 0; b < BW; b++)
            if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: drives a zero-wait and a three-wait instance against a word-array memory model.
// Define APB_MEM_PSTRB_EN to also exercise byte strobes.
module tb_apb_mem_slave;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0][31:0] paddr  = '0;
   logic [1:0][31:0] pwdata = '0;
   logic [1:0]       psel = '0, penable = '0, pwrite = '0;
   logic [1:0]       pready, pslverr;
   logic [1:0][31:0] prdata;
`ifdef APB_MEM_PSTRB_EN
   logic [1:0][3:0]  pstrb = '0;
`endif
   logic [31:0]      mem [2][256];
   int               n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3 * g)) dut (
         .clk(clk), .rst(rst), .paddr(paddr[g]), .psel(psel[g]), .penable(penable[g]),
         .pwrite(pwrite[g]), .pwdata(pwdata[g]),
`ifdef APB_MEM_PSTRB_EN
         .pstrb(pstrb[g]),
`endif
         .pready(pready[g]), .prdata(prdata[g]), .pslverr(pslverr[g]));
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++) mem[d][i] = '0;
   endfunction

   // One APB transfer; ab >= 0 aborts in that ACCESS cycle (0-based).
   task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int ab);
      int          ws = 3 * d;
      logic [31:0] idx = a >> 2;
      bit          e = idx >= 256 || a[1:0] != 2'b00;
      logic [31:0] ex;
      logic [3:0]  m;
      @(negedge clk);
      psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = wr; pwdata[d] = wd;
`ifdef APB_MEM_PSTRB_EN
      pstrb[d] = st;
      m = st;
`else
      m = 4'hF;
`endif
      #1 chk("setup_pready", 32'(pready[d]), 32'd0);
      chk("setup_prdata", prdata[d], 32'd0);
      ex = (wr || e) ? 32'd0 : mem[d][idx[7:0]];
      for (int k = 0; k <= ws; k++) begin
         @(negedge clk);
         penable[d] = 1'b1;
         paddr[d] = $urandom; pwdata[d] = $urandom; pwrite[d] = 1'($urandom);
         if (k == ab) begin
            if ($urandom_range(0, 1) == 1) psel[d] = 1'b0;
            else penable[d] = 1'b0;
         end
         #1 chk("pready", 32'(pready[d]), 32'(k == ws));
         chk("prdata", prdata[d], k == ws ? ex : 32'd0);
         chk("pslverr", 32'(pslverr[d]), 32'(k == ws && e));
         if (k == ab) break;
      end
      if (ab < 0 && wr && !e)
         for (int b = 0; b < 4; b++)
            if (m[b]) mem[d][idx[7:0]][8*b +: 8] = wd[8*b +: 8];
      if (ab >= 0) begin
         @(negedge clk);
         psel[d] = 1'b0; penable[d] = 1'b0;
         #1 chk("abort_pready", 32'(pready[d]), 32'd0);
      end
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      psel[d] = 1'b0; penable[d] = 1'b0; paddr[d] = $urandom;
      #1 chk("idle_pready", 32'(pready[d]), 32'd0);
      chk("idle_prdata", prdata[d], 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      int          r, ab;
      clear_model();
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_pready", 32'(pready[d]), 32'd0);
         chk("rst_prdata", prdata[d], 32'd0);
         chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
      end
      rst = 1'b0;
      xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, -1);
      xfer(0, 0, 32'h10, 32'h0, 4'h0, -1);
      idle(0);
      xfer(1, 0, 32'h04, 32'h0, 4'h0, -1);
      idle(1);
      xfer(0, 1, 32'h400, 32'hCAFEF00D, 4'hF, -1);
      xfer(0, 0, 32'h002, 32'h0, 4'h0, -1);
      xfer(0, 1, 32'h001, 32'h11111111, 4'hF, -1);
      xfer(0, 0, 32'h000, 32'h0, 4'h0, -1);
      xfer(0, 0, 32'h3FC, 32'h0, 4'h0, -1);
      xfer(0, 1, 32'h20, 32'h12345678, 4'hF, 0);
      xfer(0, 0, 32'h20, 32'h0, 4'h0, -1);
      xfer(1, 1, 32'h20, 32'h87654321, 4'hF, 2);
      xfer(1, 0, 32'h20, 32'h0, 4'h0, -1);
      idle(0);
      idle(1);
      xfer(1, 1, 32'h08, 32'hAAAA5555, 4'hF, -1);
      xfer(1, 0, 32'h08, 32'h0, 4'h0, -1);
      @(negedge clk);
      psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'h08; pwrite[1] = 1'b1; pwdata[1] = 32'h5A5A5A5A;
      @(negedge clk);
      penable[1] = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
      #1 chk("rst_mid_pready", 32'(pready[1]), 32'd0);
      clear_model();
      xfer(1, 0, 32'h08, 32'h0, 4'h0, -1);
      xfer(0, 0, 32'h10, 32'h0, 4'h0, -1);
`ifdef APB_MEM_PSTRB_EN
      xfer(0, 1, 32'h0C, 32'hFFFFFFFF, 4'hF, -1);
      xfer(0, 1, 32'h0C, 32'h00000000, 4'b0101, -1);
      xfer(0, 0, 32'h0C, 32'h0, 4'h0, -1);
      chk("strb_model", mem[0][3], 32'hFF00FF00);
      xfer(0, 1, 32'h0C, 32'h12345678, 4'b0000, -1);
      xfer(0, 0, 32'h0C, 32'h0, 4'hF, -1);
`endif
      for (int d = 0; d < 2; d++) begin
         idle(1 - d);
         for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            a = r < 7 ? 32'($urandom_range(0, 15)) << 2 :
                r == 7 ? (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3)) :
                r == 8 ? 32'h400 + (32'($urandom_range(0, 63)) << 2) : $urandom;
            ab = $urandom_range(0, 7) == 0 ? $urandom_range(0, 3 * d) : -1;
            xfer(d, 1'($urandom), a, $urandom, 4'($urandom), ab);
            if ($urandom_range(0, 3) == 0) idle(d);
         end
         for (int i = 0; i < 16; i++) xfer(d, 0, 32'(i) << 2, 32'h0, 4'h0, -1);
         idle(d);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
